// File: rtl/rom_shadow_loader_pkg.sv
// Shared types and default widths for the boot-time ROM-to-RAM shadow loader.
package rom_shadow_loader_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    FINISH  = 3'd4
  } state_e;

endpackage

// File: rtl/rom_shadow_loader_if.sv
// Bundles the boot-sequencer control signals and the ROM/RAM bus pins of the shadow loader.
interface rom_shadow_loader_if
  import rom_shadow_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              START;
  logic [ADDR_W-1:0] SRC;
  logic [ADDR_W-1:0] DST;
  logic [ADDR_W:0]   LEN;
  logic              BUSY;
  logic              DONE;
  logic [DATA_W-1:0] CHECKSUM;

  logic              ROM_nCS;
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [DATA_W-1:0] ROM_DO;

  logic              RAM_nCS;
  logic              RAM_nWE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_DI;
  logic              RAM_READY;

  modport master (
    input  START, SRC, DST, LEN, ROM_DO, RAM_READY,
    output BUSY, DONE, CHECKSUM, ROM_nCS, ROM_ADDR,
           RAM_nCS, RAM_nWE, RAM_ADDR, RAM_DI
  );

  modport slave (
    output START, SRC, DST, LEN, ROM_DO, RAM_READY,
    input  BUSY, DONE, CHECKSUM, ROM_nCS, ROM_ADDR,
           RAM_nCS, RAM_nWE, RAM_ADDR, RAM_DI
  );

endinterface

// File: rtl/rom_shadow_loader.sv
// Copies LEN words from the registered-output program ROM into RAM, one word every
// READ/CAPTURE/WRITE pass, accumulating a wrapping checksum of the words written.
module rom_shadow_loader
  import rom_shadow_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  rom_shadow_loader_if.master bus
);

  state_e            state_q,    state_d;
  logic [ADDR_W-1:0] srcAddr_q,  srcAddr_d;
  logic [ADDR_W-1:0] dstAddr_q,  dstAddr_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic [DATA_W-1:0] ramDi_q,    ramDi_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      srcAddr_q  <= '0;
      dstAddr_q  <= '0;
      count_q    <= '0;
      checksum_q <= '0;
      ramDi_q    <= '0;
    end else begin
      state_q    <= state_d;
      srcAddr_q  <= srcAddr_d;
      dstAddr_q  <= dstAddr_d;
      count_q    <= count_d;
      checksum_q <= checksum_d;
      ramDi_q    <= ramDi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    srcAddr_d  = srcAddr_q;
    dstAddr_d  = dstAddr_q;
    count_d    = count_q;
    checksum_d = checksum_q;
    ramDi_d    = ramDi_q;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          checksum_d = '0;
          // A zero-length request skips the bus entirely and just reports completion.
          if (bus.LEN == '0) begin
            state_d = FINISH;
          end else begin
            srcAddr_d = bus.SRC;
            dstAddr_d = bus.DST;
            count_d   = bus.LEN;
            state_d   = READ;
          end
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        ramDi_d = bus.ROM_DO;
        state_d = WRITE;
      end
      WRITE: begin
        if (bus.RAM_READY) begin
          checksum_d = checksum_q + ramDi_q;
          srcAddr_d  = srcAddr_q + ADDR_W'(1);
          dstAddr_d  = dstAddr_q + ADDR_W'(1);
          count_d    = count_q - (ADDR_W + 1)'(1);
          state_d    = (count_q == (ADDR_W + 1)'(1)) ? FINISH : READ;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.BUSY     = (state_q == READ) || (state_q == CAPTURE) || (state_q == WRITE);
  assign bus.DONE     = (state_q == FINISH);
  assign bus.CHECKSUM = checksum_q;
  assign bus.ROM_nCS  = (state_q != READ);
  assign bus.ROM_ADDR = srcAddr_q;
  assign bus.RAM_nCS  = (state_q != WRITE);
  assign bus.RAM_nWE  = (state_q != WRITE);
  assign bus.RAM_ADDR = dstAddr_q;
  assign bus.RAM_DI   = ramDi_q;

endmodule

// File: tb/tb_rom_shadow_loader.sv
// Directed bench for rom_shadow_loader with a registered ROM model and a stallable RAM model.
module tb_rom_shadow_loader;

  logic CLK = 1'b0;
  logic RESET;

  rom_shadow_loader_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  rom_shadow_loader #(.ADDR_W(12), .DATA_W(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  logic [15:0] rom [0:4095];
  logic [15:0] ram [0:4095];
  logic        armModel = 1'b0;
  int          stallInit = 0;
  int          stallWord = 1;
  int          wordIdx = 0;
  int          stallLeft = 0;
  int          edgeCount = 0;
  int          checkCount = 0;
  int          errorCount = 0;

  int          startEdge;
  logic [11:0] romLog [0:7];
  logic [11:0] ramLog [0:7];
  int          romN, ramN, bothSel, stallN, unstable;
  logic [11:0] stallAddr;
  logic [15:0] stallData;

  always @(posedge CLK) edgeCount <= edgeCount + 1;

  always @(posedge CLK) begin
    if (!bus.ROM_nCS) bus.ROM_DO <= rom[bus.ROM_ADDR];
  end

  // RAM stalls for stallInit write cycles on word stallWord, then accepts.
  assign bus.RAM_READY = !(wordIdx == stallWord && stallLeft != 0);

  always @(posedge CLK) begin
    if (armModel) begin
      wordIdx   <= 0;
      stallLeft <= stallInit;
      for (int i = 0; i < 4096; i++) ram[i] <= 16'hDEAD;
    end else if (!bus.RAM_nCS && !bus.RAM_nWE) begin
      if (bus.RAM_READY) begin
        ram[bus.RAM_ADDR] <= bus.RAM_DI;
        wordIdx <= wordIdx + 1;
      end else if (stallLeft != 0) begin
        stallLeft <= stallLeft - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] src, input logic [11:0] dst,
                               input logic [12:0] len, input int stall);
    @(negedge CLK);
    bus.SRC   = src;
    bus.DST   = dst;
    bus.LEN   = len;
    bus.START = 1'b1;
    stallInit = stall;
    armModel  = 1'b1;
    romN = 0; ramN = 0; bothSel = 0; stallN = 0; unstable = 0;
    startEdge = edgeCount + 1;
  endtask

  task automatic waitCopy(input int pulseAt, output int doneCyc, output logic doneAfter);
    int cyc;
    doneCyc = -1;
    doneAfter = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      cyc = edgeCount - startEdge + 1;
      if (cyc == 1) begin
        bus.START = 1'b0;
        armModel  = 1'b0;
      end
      if (pulseAt != 0 && cyc == pulseAt) begin
        bus.START = 1'b1; bus.SRC = 12'h000; bus.DST = 12'h000; bus.LEN = 13'd1;
      end else if (pulseAt != 0 && cyc == pulseAt + 1) begin
        bus.START = 1'b0;
      end
      if (!bus.ROM_nCS) begin
        if (romN < 8) romLog[romN] = bus.ROM_ADDR;
        romN++;
      end
      if (!bus.RAM_nCS && !bus.RAM_nWE && bus.RAM_READY) begin
        if (ramN < 8) ramLog[ramN] = bus.RAM_ADDR;
        ramN++;
      end
      if (!bus.ROM_nCS && !bus.RAM_nCS) bothSel++;
      if (!bus.RAM_nCS && !bus.RAM_READY) begin
        if (stallN == 0) begin
          stallAddr = bus.RAM_ADDR;
          stallData = bus.RAM_DI;
        end else if (stallAddr !== bus.RAM_ADDR || stallData !== bus.RAM_DI) begin
          unstable++;
        end
        stallN++;
      end
      if (bus.DONE) begin
        doneCyc = cyc;
        break;
      end
    end
    @(negedge CLK);
    doneAfter = bus.DONE;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ctl"}, {27'd0, bus.BUSY, bus.DONE, bus.ROM_nCS, bus.RAM_nCS, bus.RAM_nWE},
                32'b00111);
    checkOutput({tag, "_romaddr"}, {20'd0, bus.ROM_ADDR}, 32'h0);
    checkOutput({tag, "_ramaddr"}, {20'd0, bus.RAM_ADDR}, 32'h0);
    checkOutput({tag, "_ramdi"}, {16'd0, bus.RAM_DI}, 32'h0);
    checkOutput({tag, "_cksum"}, {16'd0, bus.CHECKSUM}, 32'h0);
  endtask

  int   doneCyc;
  logic doneAfter;
  int   doneSeen;
  logic hit;

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 16'h0;
    rom[12'h000] = 16'h1111; rom[12'h001] = 16'h2222; rom[12'h002] = 16'h3333;
    rom[12'hFFE] = 16'hAAAA; rom[12'hFFF] = 16'hBBBB;
    rom[12'h010] = 16'h0101; rom[12'h011] = 16'h0202; rom[12'h012] = 16'h0303;
    rom[12'h020] = 16'h1234; rom[12'h021] = 16'h4321;
    rom[12'h200] = 16'hFFFF; rom[12'h201] = 16'h0002;
    bus.START = 1'b0; bus.SRC = '0; bus.DST = '0; bus.LEN = '0; bus.ROM_DO = '0;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checkResetValues("reset");
    RESET = 1'b0;

    // Basic three-word copy.
    applyStimulus(12'h000, 12'h100, 13'd3, 0);
    waitCopy(0, doneCyc, doneAfter);
    checkOutput("t1_done_cycle", doneCyc, 10);
    checkOutput("t1_done_pulse", {31'd0, doneAfter}, 0);
    checkOutput("t1_cksum", {16'd0, bus.CHECKSUM}, 32'h6666);
    checkOutput("t1_ram", {ram[12'h100], ram[12'h101]}, 32'h1111_2222);
    checkOutput("t1_ram2", {16'd0, ram[12'h102]}, 32'h3333);
    checkOutput("t1_bothsel", bothSel, 0);

    // Zero-length request.
    applyStimulus(12'h005, 12'h006, 13'd0, 0);
    waitCopy(0, doneCyc, doneAfter);
    checkOutput("t2_done_cycle", doneCyc, 1);
    checkOutput("t2_selects", romN + ramN, 0);
    checkOutput("t2_cksum", {16'd0, bus.CHECKSUM}, 32'h0);

    // Address wrap on both ports.
    applyStimulus(12'hFFE, 12'hFFF, 13'd3, 0);
    waitCopy(0, doneCyc, doneAfter);
    checkOutput("t3_romaddr", {romLog[0], romLog[1], 8'd0}, {12'hFFE, 12'hFFF, 8'd0});
    checkOutput("t3_romaddr2", {20'd0, romLog[2]}, 32'h000);
    checkOutput("t3_ramaddr", {ramLog[0], ramLog[1], 8'd0}, {12'hFFF, 12'h000, 8'd0});
    checkOutput("t3_ramaddr2", {20'd0, ramLog[2]}, 32'h001);
    checkOutput("t3_cksum", {16'd0, bus.CHECKSUM}, 32'h7776);
    checkOutput("t3_ram", {ram[12'hFFF], ram[12'h000]}, 32'hAAAA_BBBB);

    // Five-cycle RAM stall on the second word.
    applyStimulus(12'h010, 12'h040, 13'd3, 5);
    waitCopy(0, doneCyc, doneAfter);
    checkOutput("t4_done_cycle", doneCyc, 15);
    checkOutput("t4_stall_cycles", stallN, 5);
    checkOutput("t4_stable", unstable, 0);
    checkOutput("t4_rom_selects", romN, 3);
    checkOutput("t4_cksum", {16'd0, bus.CHECKSUM}, 32'h0606);
    checkOutput("t4_ram", {ram[12'h041], ram[12'h042]}, 32'h0202_0303);

    // Reset during the (stalled) write of word 2 of a four-word copy.
    applyStimulus(12'h030, 12'h060, 13'd4, 20);
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      bus.START = 1'b0;
      armModel  = 1'b0;
      if (!bus.RAM_nCS && wordIdx == 1) begin
        hit = 1'b1;
        break;
      end
    end
    checkOutput("t5_reached_write", {31'd0, hit}, 1);
    RESET = 1'b1;
    @(negedge CLK);
    checkResetValues("t5");
    RESET = 1'b0;
    doneSeen = 0;
    repeat (5) begin
      @(negedge CLK);
      if (bus.DONE || bus.BUSY) doneSeen++;
    end
    checkOutput("t5_no_done", doneSeen, 0);
    checkOutput("t5_no_word2", {16'd0, ram[12'h061]}, 32'hDEAD);
    applyStimulus(12'h020, 12'h050, 13'd2, 0);
    waitCopy(0, doneCyc, doneAfter);
    checkOutput("t5_fresh_cycle", doneCyc, 7);
    checkOutput("t5_fresh_cksum", {16'd0, bus.CHECKSUM}, 32'h5555);
    checkOutput("t5_fresh_ram", {ram[12'h050], ram[12'h051]}, 32'h1234_4321);

    // START while busy is ignored; checksum overflow truncates.
    applyStimulus(12'h200, 12'h300, 13'd2, 0);
    waitCopy(3, doneCyc, doneAfter);
    checkOutput("t6_done_cycle", doneCyc, 7);
    checkOutput("t6_cksum", {16'd0, bus.CHECKSUM}, 32'h0001);
    checkOutput("t6_romaddr", {romLog[0], romLog[1], 8'd0}, {12'h200, 12'h201, 8'd0});
    checkOutput("t6_ram", {ram[12'h300], ram[12'h301]}, 32'hFFFF_0002);
    checkOutput("t6_ram0_untouched", {16'd0, ram[12'h000]}, 32'hDEAD);
    doneSeen = 0;
    repeat (4) begin
      @(negedge CLK);
      if (bus.BUSY) doneSeen++;
    end
    checkOutput("t6_idle_after", doneSeen, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
